// File: rtl/seg_display_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter_pkg
// Shared definitions for the seven-segment display arbiter:
//   - state_e     : arbiter FSM encodings (idle, granted to source 0 / 1)
//   - SEG_BLANK   : all segments dark (active-low)
//   - GLYPH_TABLE : active-low segment patterns for nibbles 0..F,
//                   bit order {g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
package seg_display_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT0 = 2'd1,
      S_GNT1 = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Digits 0-9, then hex glyphs A, b, C, d, E, F.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_display_arbiter_if.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter_if
// Bundles the two requester channels and the display pins.
//   master : requester / board side (drives requests and data, sees grants
//            and pins)
//   slave  : the arbiter (consumes requests and data, drives grants and pins)
// Signals:
//   i_w_req0/1   request level, i_w_data0/1 16-bit value (nibble k -> digit k),
//   i_w_dp0/1    decimal points (bit k -> digit k, 1 = lit),
//   o_r_gnt0/1   registered grants, o_r_AN0..3 anodes (active-low),
//   o_r_CA..CG, o_r_DP segment cathodes (active-low).
// -----------------------------------------------------------------------------
interface seg_display_arbiter_if;

   logic        i_w_req0;
   logic [15:0] i_w_data0;
   logic [3:0]  i_w_dp0;
   logic        i_w_req1;
   logic [15:0] i_w_data1;
   logic [3:0]  i_w_dp1;

   logic        o_r_gnt0;
   logic        o_r_gnt1;
   logic        o_r_AN0, o_r_AN1, o_r_AN2, o_r_AN3;
   logic        o_r_CA, o_r_CB, o_r_CC, o_r_CD, o_r_CE, o_r_CF, o_r_CG;
   logic        o_r_DP;

   modport master (
      output i_w_req0, i_w_data0, i_w_dp0,
      output i_w_req1, i_w_data1, i_w_dp1,
      input  o_r_gnt0, o_r_gnt1,
      input  o_r_AN0, o_r_AN1, o_r_AN2, o_r_AN3,
      input  o_r_CA, o_r_CB, o_r_CC, o_r_CD, o_r_CE, o_r_CF, o_r_CG,
      input  o_r_DP
   );

   modport slave (
      input  i_w_req0, i_w_data0, i_w_dp0,
      input  i_w_req1, i_w_data1, i_w_dp1,
      output o_r_gnt0, o_r_gnt1,
      output o_r_AN0, o_r_AN1, o_r_AN2, o_r_AN3,
      output o_r_CA, o_r_CB, o_r_CC, o_r_CD, o_r_CE, o_r_CF, o_r_CG,
      output o_r_DP
   );

endinterface

// File: rtl/seg_display_arbiter_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational nibble to seven-segment decoder, active-low outputs.
//   nibble_i : 4-bit value 0..F
//   seg_o    : {g, f, e, d, c, b, a}, 0 = segment lit
// -----------------------------------------------------------------------------
module hex_to_7seg
   import seg_display_arbiter_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit multiplexed seven-segment display between a
// high-priority alert source (0) and a normal source (1). Grants change only
// at frame boundaries (slot wrap with digit 3 -> 0); a granted source-1 frame
// is held at least HOLD_FRAMES frames before source 0 may preempt it.
// Each digit slot starts with BLANK_CYCLES of dark anodes to avoid ghosting.
// Ports:
//   i_w_clk   : system clock
//   i_w_reset : asynchronous active-high reset
//   bus       : requester channels and display pins (slave modport)
// -----------------------------------------------------------------------------
module seg_display_arbiter
   import seg_display_arbiter_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int HOLD_FRAMES  = 4
) (
   input  logic                  i_w_clk,
   input  logic                  i_w_reset,
   seg_display_arbiter_if.slave  bus
);

   localparam int SLOT_W = $clog2(SCAN_DIV);
   // One extra code point so the counter can hold the saturation value itself.
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q,  slot_d;
   logic [1:0]          digit_q, digit_d;
   logic [HOLD_W-1:0]   hold_q,  hold_d;
   logic                gnt0_q,  gnt0_d;
   logic                gnt1_q,  gnt1_d;
   logic [3:0]          an_q,    an_d;
   logic [6:0]          seg_q,   seg_d;
   logic                dp_q,    dp_d;

   logic                slot_wrap;
   logic                frame_end;
   logic [15:0]         src_data;
   logic [3:0]          src_dp;
   logic [3:0]          nibble;
   logic [6:0]          glyph;

   assign slot_wrap = (slot_q == SLOT_LAST);
   assign frame_end = slot_wrap && (digit_q == 2'd3);

   // Arbitration: evaluated only on the frame-boundary cycle.
   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (frame_end) begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_w_req0)      state_d = S_GNT0;
               else if (bus.i_w_req1) state_d = S_GNT1;
            end
            S_GNT0: begin
               if (!bus.i_w_req0) state_d = bus.i_w_req1 ? S_GNT1 : S_IDLE;
            end
            S_GNT1: begin
               if (!bus.i_w_req1)
                  state_d = bus.i_w_req0 ? S_GNT0 : S_IDLE;
               else if (bus.i_w_req0 && (hold_q >= HOLD_MAX))
                  state_d = S_GNT0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Scan and hold counters.
   always_comb begin
      slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
      digit_d = slot_wrap ? digit_q + 2'd1 : digit_q;
      hold_d  = hold_q;
      if (frame_end) begin
         if (state_d != state_q)    hold_d = '0;
         else if (hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
      end
   end

   // Source selection follows the next state, so the digit latched on a
   // grant-change edge already comes from the new owner.
   assign src_data = (state_d == S_GNT0) ? bus.i_w_data0 : bus.i_w_data1;
   assign src_dp   = (state_d == S_GNT0) ? bus.i_w_dp0   : bus.i_w_dp1;
   assign nibble   = src_data[{digit_d, 2'b00} +: 4];

   hex_to_7seg u_hex_to_7seg (
      .nibble_i (nibble),
      .seg_o    (glyph)
   );

   // Output next-state: segments latch once per slot, anodes track the
   // blanking window of the slot the counter is entering.
   always_comb begin
      seg_d  = seg_q;
      dp_d   = dp_q;
      an_d   = 4'hF;
      gnt0_d = (state_d == S_GNT0);
      gnt1_d = (state_d == S_GNT1);
      if (slot_wrap) begin
         if (state_d == S_IDLE) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
         end else begin
            seg_d = glyph;
            dp_d  = ~src_dp[digit_d];
         end
      end
      if ((state_d != S_IDLE) && (slot_d >= BLANK_END)) an_d[digit_d] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of the others regardless of order.
   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         digit_q <= '0;
         hold_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         an_q    <= 4'hF;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         digit_q <= digit_d;
         hold_q  <= hold_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.o_r_gnt0 = gnt0_q;
   assign bus.o_r_gnt1 = gnt1_q;
   assign bus.o_r_AN0  = an_q[0];
   assign bus.o_r_AN1  = an_q[1];
   assign bus.o_r_AN2  = an_q[2];
   assign bus.o_r_AN3  = an_q[3];
   assign bus.o_r_CA   = seg_q[0];
   assign bus.o_r_CB   = seg_q[1];
   assign bus.o_r_CC   = seg_q[2];
   assign bus.o_r_CD   = seg_q[3];
   assign bus.o_r_CE   = seg_q[4];
   assign bus.o_r_CF   = seg_q[5];
   assign bus.o_r_CG   = seg_q[6];
   assign bus.o_r_DP   = dp_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Directed bench for seg_display_arbiter with SCAN_DIV=8, BLANK_CYCLES=2,
// HOLD_FRAMES=2. The bench keeps its own cycle index since reset release:
// at index k the slot count is k%8, the digit is (k/8)%4 and the edge that
// produces a multiple of 32 is a frame boundary. Observed outputs are packed
// as {gnt1,gnt0, AN3..AN0, CG..CA, DP}. Glyphs (active-low, {g..a}):
// 1=79 2=24 3=30 4=19 5=12 8=00 A=08 b=03 C=46 d=21, dark=7F.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [13:0] obs;
   logic [13:0] exp_v;

   always #5 clk = ~clk;

   seg_display_arbiter_if bus ();

   seg_display_arbiter #(
      .SCAN_DIV     (8),
      .BLANK_CYCLES (2),
      .HOLD_FRAMES  (2)
   ) dut (
      .i_w_clk   (clk),
      .i_w_reset (rst),
      .bus       (bus)
   );

   assign obs = {bus.o_r_gnt1, bus.o_r_gnt0,
                 bus.o_r_AN3, bus.o_r_AN2, bus.o_r_AN1, bus.o_r_AN0,
                 bus.o_r_CG, bus.o_r_CF, bus.o_r_CE, bus.o_r_CD,
                 bus.o_r_CC, bus.o_r_CB, bus.o_r_CA, bus.o_r_DP};

   // Bench-side cycle index, restarted by the same reset as the design.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic goto(input int k);
      int budget;
      budget = 2000;
      while (cyc < k && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (cyc != k) begin
         n_cmp++;
         n_bad++;
         $display("FAIL goto: reached cycle %0d, required %0d", cyc, k);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_w_req0 = 1'b0; bus.i_w_data0 = 16'h0; bus.i_w_dp0 = 4'h0;
      bus.i_w_req1 = 1'b0; bus.i_w_data1 = 16'h0; bus.i_w_dp1 = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_v = {2'b00, 4'hF, 7'h7F, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_hold: got %b want %b", obs, exp_v); end
      apply_reset();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs, exp_v); end
      goto(20); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL idle_dark: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_single_req1();
      apply_reset();
      bus.i_w_data1 = 16'h1234; bus.i_w_dp1 = 4'b0100; bus.i_w_req1 = 1'b1;
      goto(31); exp_v = {2'b00, 4'hF, 7'h7F, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_before_boundary: got %b want %b", obs, exp_v); end
      goto(32); exp_v = {2'b10, 4'hF, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_grant_blank0: got %b want %b", obs, exp_v); end
      goto(33); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_blank1: got %b want %b", obs, exp_v); end
      goto(34); exp_v = {2'b10, 4'hE, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_an0_on: got %b want %b", obs, exp_v); end
      goto(39); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_an0_end: got %b want %b", obs, exp_v); end
      goto(40); exp_v = {2'b10, 4'hF, 7'h30, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_digit1_blank: got %b want %b", obs, exp_v); end
      goto(42); exp_v = {2'b10, 4'hD, 7'h30, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_digit1: got %b want %b", obs, exp_v); end
      goto(48); exp_v = {2'b10, 4'hF, 7'h24, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_digit2_blank: got %b want %b", obs, exp_v); end
      goto(50); exp_v = {2'b10, 4'hB, 7'h24, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_digit2_dp: got %b want %b", obs, exp_v); end
      goto(58); exp_v = {2'b10, 4'h7, 7'h79, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_digit3: got %b want %b", obs, exp_v); end
      // Mid-slot data change must wait for the next slot start.
      goto(60); bus.i_w_data1 = 16'h5678; bus.i_w_dp1 = 4'b0001;
      goto(61); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_midslot_ignored: got %b want %b", obs, exp_v); end
      goto(66); exp_v = {2'b10, 4'hE, 7'h00, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_new_data: got %b want %b", obs, exp_v); end
      goto(70); bus.i_w_req1 = 1'b0;
      goto(95); exp_v = {2'b10, 4'h7, 7'h12, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_release_wait: got %b want %b", obs, exp_v); end
      goto(96); exp_v = {2'b00, 4'hF, 7'h7F, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_idle: got %b want %b", obs, exp_v); end
      goto(98); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL r1_idle_anodes: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_priority();
      apply_reset();
      bus.i_w_data0 = 16'hABCD; bus.i_w_data1 = 16'h1234;
      bus.i_w_req0 = 1'b1; bus.i_w_req1 = 1'b1;
      goto(32); exp_v = {2'b01, 4'hF, 7'h21, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_grant0: got %b want %b", obs, exp_v); end
      goto(34); exp_v = {2'b01, 4'hE, 7'h21, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_digit0_d: got %b want %b", obs, exp_v); end
      goto(42); exp_v = {2'b01, 4'hD, 7'h46, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_digit1_C: got %b want %b", obs, exp_v); end
      goto(50); exp_v = {2'b01, 4'hB, 7'h03, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_digit2_b: got %b want %b", obs, exp_v); end
      goto(58); exp_v = {2'b01, 4'h7, 7'h08, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_digit3_A: got %b want %b", obs, exp_v); end
      goto(160); exp_v = {2'b01, 4'hF, 7'h21, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_no_preempt: got %b want %b", obs, exp_v); end
      goto(170); bus.i_w_req0 = 1'b0;
      goto(186); exp_v = {2'b01, 4'h7, 7'h08, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_drop_keep: got %b want %b", obs, exp_v); end
      goto(191); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_drop_frame_end: got %b want %b", obs, exp_v); end
      goto(192); exp_v = {2'b10, 4'hF, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_handover: got %b want %b", obs, exp_v); end
      goto(194); exp_v = {2'b10, 4'hE, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_handover_an: got %b want %b", obs, exp_v); end
      goto(200); bus.i_w_req1 = 1'b0;
      goto(224); exp_v = {2'b00, 4'hF, 7'h7F, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pri_both_drop_idle: got %b want %b", obs, exp_v); end
   endtask

   // Grant 1 starts at 32 with hold 0; hold reaches 2 at the 96 boundary,
   // so req0 takes over at 128.
   task automatic test_preempt();
      apply_reset();
      bus.i_w_data0 = 16'hABCD; bus.i_w_data1 = 16'h1234; bus.i_w_req1 = 1'b1;
      goto(32); exp_v = {2'b10, 4'hF, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_grant1: got %b want %b", obs, exp_v); end
      goto(33); bus.i_w_req0 = 1'b1;
      goto(64); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_hold_f1: got %b want %b", obs, exp_v); end
      goto(96); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_hold_f2: got %b want %b", obs, exp_v); end
      goto(104); exp_v = {2'b10, 4'hF, 7'h30, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_unmixed: got %b want %b", obs, exp_v); end
      goto(127); exp_v = {2'b10, 4'h7, 7'h79, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_last_of_gnt1: got %b want %b", obs, exp_v); end
      goto(128); exp_v = {2'b01, 4'hF, 7'h21, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_take_over: got %b want %b", obs, exp_v); end
      goto(130); bus.i_w_req0 = 1'b0;
      goto(160); exp_v = {2'b10, 4'hF, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_back_to_1: got %b want %b", obs, exp_v); end
      goto(161); bus.i_w_req0 = 1'b1;
      goto(192); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_hold_cleared: got %b want %b", obs, exp_v); end
      goto(224); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_hold_again: got %b want %b", obs, exp_v); end
      goto(256); exp_v = {2'b01, 4'hF, 7'h21, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_take_over2: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      bus.i_w_data1 = 16'h1234; bus.i_w_req1 = 1'b1;
      goto(34); exp_v = {2'b10, 4'hE, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mr_lit: got %b want %b", obs, exp_v); end
      #2 rst = 1'b1;
      #1 exp_v = {2'b00, 4'hF, 7'h7F, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mr_async_blank: got %b want %b", obs, exp_v); end
      @(negedge clk);
      rst = 1'b0;
      goto(31); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mr_restart_idle: got %b want %b", obs, exp_v); end
      goto(32); exp_v = {2'b10, 4'hF, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mr_restart_grant: got %b want %b", obs, exp_v); end
      goto(34); exp_v = {2'b10, 4'hE, 7'h19, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mr_restart_digit0: got %b want %b", obs, exp_v); end
   endtask

   initial begin
      bus.i_w_req0 = 1'b0; bus.i_w_data0 = 16'h0; bus.i_w_dp0 = 4'h0;
      bus.i_w_req1 = 1'b0; bus.i_w_data1 = 16'h0; bus.i_w_dp1 = 4'h0;
      test_reset();
      test_single_req1();
      test_priority();
      test_preempt();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 4-digit multiplexed seven-segment display between two requesters: a high-priority alert source and a normal source such as the minutes:seconds counter. The block grants the display to one requester at frame boundaries and scans the granted 16-bit value across the four digits. It blanks the anodes at each slot start to prevent ghosting, and holds each grant for a minimum number of frames to avoid flicker. It sits between the counter/alert logic and the board pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off.
- HOLD_FRAMES, 4: minimum full frames a grant is held before preemption.

- i_w_clk  in  1  system clock.
- i_w_reset  in  1  asynchronous, active-high reset.
- i_w_req0  in  1  high-priority requester wants display.
- i_w_data0  in  16  requester 0 value, nibble k → digit k (digit 0 = AN0).
- i_w_dp0  in  4  requester 0 decimal points, bit k → digit k, 1 = lit.
- i_w_req1  in  1  normal requester wants display.
- i_w_data1  in  16  requester 1 value.
- i_w_dp1  in  4  requester 1 decimal points.
- o_r_gnt0, o_r_gnt1  out  1 each  registered grants, one-hot or both 0.
- o_r_AN0..o_r_AN3  out  1 each  digit anodes, active-low.
- o_r_CA..o_r_CG, o_r_DP  out  1 each  segment cathodes, active-low.

## Operation
- Reset: all anodes, cathodes and DP are 1 (dark). Grants are 0. FSM is in S_IDLE. Slot counter, digit index and hold counter are 0.
- Scan: slot counter runs 0..SCAN_DIV-1. At wrap, digit index increments 0→1→2→3→0. A frame is 4 slots.
- At slot count 0, the granted source's nibble and DP bit for the current digit are latched into the segment registers. Mid-slot input changes are ignored.
- Anode of the current digit is low only while count ≥ BLANK_CYCLES. Otherwise all anodes are high.
- Decode: nibble 0–9 gives decimal glyphs; A–F gives hex glyphs A, b, C, d, E, F.
- In S_IDLE, cathodes and anodes remain all 1.
- Frame boundary = the cycle where the slot counter wraps and the digit index goes 3→0. All grant decisions are made only there.
  - S_IDLE: req0 → S_GNT0; else req1 → S_GNT1; else stay.
  - S_GNT0: if req0 is low → S_GNT1 if req1, else S_IDLE. Otherwise stay; req1 never preempts.
  - S_GNT1: if req1 is low → S_GNT0 if req0, else S_IDLE. If req0 and hold ≥ HOLD_FRAMES → S_GNT0. Otherwise stay.
- Hold counter:
  - Clears on any grant change.
  - Increments at each frame boundary while the grant is unchanged.
  - Saturates at HOLD_FRAMES.
  - Is unconditional: a requester that drops its request is released at the next frame boundary regardless of hold.
- Simultaneous req0 and req1 from S_IDLE: req0 wins.
- Requests are level-sensitive and need not be held after release. Data must be stable only at slot count 0.

## Timing
- o_r_gnt* update on the same edge the digit index returns to 0. The new source's digit 0 is latched on that same edge, so there is no mixed-source frame.
- Request-to-grant latency: 1 to 4·SCAN_DIV cycles from S_IDLE.
- Preemption of grant 1 by req0: at least HOLD_FRAMES frames after grant 1 starts.
- Segment output changes lag the latch edge by 0 cycles (registered outputs).
- Reset asserted mid-frame blanks all outputs immediately (asynchronous). Scanning restarts at digit 0, slot count 0, after deassertion.
- All counters sized by $clog2 of their parameter. No counter wraps beyond its terminal value.

## Structure
- Shared package: state encodings S_IDLE, S_GNT0, S_GNT1 (2-bit) and the 16-entry active-low glyph constants.
- Sub-module hex_to_7seg: combinational 4-bit nibble → 7-bit active-low segments, reused by other display blocks.
- FSM, scan counter and hold counter live in the top module.

## Test plan
Benches use SCAN_DIV=8, BLANK_CYCLES=2, HOLD_FRAMES=2.
- Reset → all AN/C*/DP = 1, gnt = 00. Mid-frame reset re-blanks within the same cycle.
- req1=1, data1=0x1234, dp1=0b0100 → gnt1 at next frame boundary. AN0 low on cycles 2–7 of slot 0 showing "4". Digit 2 shows "2" with DP lit. Anodes are high on cycles 0–1 of every slot.
- req0 and req1 asserted together from idle → gnt0 only. data0=0xABCD shows d, C, b, A on AN0..AN3.
- GNT1 held, req0 rises at frame 0 → gnt1 holds through 2 full frames, then gnt0 at the following boundary. There is never a frame mixing data0 and data1.
- GNT0 held, req1 high, req0 drops mid-frame → gnt0 kept until the frame end, then gnt1. In the reverse case, req1 never preempts req0.
- Both requests drop → S_IDLE at next boundary, all outputs 1. data changes mid-slot do not alter segments until the next slot start.
